lmsm_sequencer: RTL and testbench
=================================

Name: lmsm_sequencer

Overview:
- Multi-register transfer sequencer for LM/SM (load/store multiple) instructions; sits directly upstream of the register file.
- Walks an 8-bit register list from lowest to highest set bit and drives register-file addresses and write enable.
- Issues one memory request per selected register at consecutive word addresses starting from a base address.
- The main controller FSM hands off to it with start and resumes on done.

Parameters:
- DATA_W, 16, datapath/address width
- NREG, 8, architectural register count (list width)
- REG_AW, 3, register address width (clog2 NREG)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin transfer; sampled only in IDLE
- is_store  in  1  1=SM (reg->mem), 0=LM (mem->reg); latched at start
- reg_list  in  NREG  register select mask; latched at start
- base_addr  in  DATA_W  first memory address; latched at start
- base_reg  in  REG_AW  base register index; used only with the optional feature
- rf_rdata  in  DATA_W  register-file read data (port A)
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completes current request
- rf_raddr  out  REG_AW  register-file read address (addrA)
- rf_waddr  out  REG_AW  register-file write address (addrC)
- rf_wdata  out  DATA_W  register-file write data
- rf_we  out  1  register-file write enable (regw)
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write (SM)
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  memory write data
- busy  out  1  sequencer active
- done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, XFER, WB (feature only), DONE. Reset forces IDLE; all outputs are 0 and internal mask/address registers are cleared.
- IDLE: start=1 latches reg_list->mask, base_addr->addr, is_store->dir; next state XFER. busy rises in the following cycle.
- XFER with mask==0 (empty list or finished): go to DONE (or WB if feature). No memory request is issued for an empty list.
- XFER with mask!=0:
  - idx = index of lowest set bit in mask.
  - mem_req=1, mem_addr=addr, mem_we=dir.
  - rf_raddr=idx, rf_waddr=idx.
  - mem_wdata=rf_rdata (combinational pass-through).
  - Outputs hold stable until mem_ack.
- Cycle with mem_ack=1 in XFER:
  - If LM: rf_we=1 and rf_wdata=mem_rdata in that same cycle.
  - Bit idx is cleared in mask; addr <= addr+1, wrapping modulo 2^DATA_W (0xFFFF+1=0x0000).
  - One transfer per ack. mem_ack while mem_req=0 is ignored.
- Throughput: one register per ack; back-to-back acks are allowed (minimum 1 cycle per register).
- DONE: done=1 for exactly one cycle, busy=0 in that cycle; next state IDLE.
- start while busy or in DONE is ignored, with no queuing.
- busy=1 in XFER and WB.
- rf_we is never asserted during an SM.
- Reset asserted mid-transfer: immediate return to IDLE with rf_we, mem_req and done deasserted. No further writes occur, and completed writes are not undone.

Optional Feature:
- Macro LMSM_BASE_WB_EN.
- Defined:
  - After the last transfer, the WB state lasts one cycle with rf_we=1, rf_waddr=base_reg, rf_wdata=final addr (base + popcount(list)), mem_req=0.
  - WB then goes to DONE. WB also runs for an empty list (writes base unchanged).
- Undefined: WB state absent; XFER goes directly to DONE and base_reg is unused.

Decomposition:
- Shared package holds the state enum (IDLE/XFER/WB/DONE), DATA_W/NREG/REG_AW constants, and the LM/SM direction encoding.
- One natural sub-module: lsb_prio_enc (NREG-bit mask -> REG_AW index plus valid), pure combinational, reusable by the decoder.

Test Plan:
- LM: list=8'b1000_0101, base=0x0010, ack every cycle -> writes R0<=mem[0x10], R2<=mem[0x11], R7<=mem[0x12]; done pulse 5 cycles after start.
- SM: list=8'b0000_0110, base=0x0100, ack delayed 3 cycles each -> mem_we=1, mem_addr 0x0100 then 0x0101 with data R1, R2; rf_we never 1; each request held stable until ack.
- Empty list=0x00 -> no mem_req; done 2 cycles after start. With LMSM_BASE_WB_EN: a WB write of base to base_reg precedes done.
- Wrap: list=0x03, base=0xFFFF -> addresses 0xFFFF then 0x0000. With the feature, base_reg<=0x0001.
- start pulsed while busy with a different list -> ignored; original transfer completes unchanged.
- reset low during the second transfer of an 8-register LM -> outputs 0 at once; after release, state is IDLE and no further rf_we occurs.

Source files
------------

// File: rtl/lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM multi-register transfer sequencer.
// The optional base-register writeback (WB state) is built when LMSM_BASE_WB_EN is defined.
package lmsm_sequencer_pkg;

  localparam int LMSM_DATA_W = 16;  // datapath / memory address width
  localparam int LMSM_NREG   = 8;   // architectural registers (register-list width)
  localparam int LMSM_REG_AW = 3;   // register address width, clog2(LMSM_NREG)

  // Transfer direction as latched at start from is_store.
  localparam logic DIR_LM = 1'b0;   // memory -> register file
  localparam logic DIR_SM = 1'b1;   // register file -> memory

  // Sequencer states. ST_WB is only reachable when LMSM_BASE_WB_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/lmsm_sequencer_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: NREG-bit mask -> index of its lowest
// set bit, plus a valid flag that is 0 when the mask is empty.
module lsb_prio_enc
  import lmsm_sequencer_pkg::*;
#(
  parameter int NREG   = LMSM_NREG,
  parameter int REG_AW = LMSM_REG_AW
) (
  input  logic [NREG-1:0]   mask_i,
  output logic [REG_AW-1:0] idx_o,
  output logic              valid_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = REG_AW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks a latched register list from the lowest to the
// highest set bit, issuing one memory request per register at consecutive
// word addresses and driving the register-file ports alongside.
// Define LMSM_BASE_WB_EN to add a one-cycle WB state that writes the final
// address (base + popcount(list)) back to base_reg before done.
//
// Memory handshake: mem_req is held high with mem_addr, mem_we, mem_wdata,
// rf_raddr and rf_waddr stable until the cycle in which mem_ack is high;
// that cycle completes exactly one transfer (for LM, rf_we/rf_wdata are
// asserted combinationally in that same cycle). mem_ack while mem_req is
// low is ignored. Back-to-back acks give one register per cycle.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
#(
  parameter int DATA_W = LMSM_DATA_W,
  parameter int NREG   = LMSM_NREG,
  parameter int REG_AW = LMSM_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREG-1:0]   reg_list,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [REG_AW-1:0] base_reg,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [REG_AW-1:0] rf_raddr,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [NREG-1:0]   mask_q;   // registers still to transfer
  logic [DATA_W-1:0] addr_q;   // address of the next transfer
  logic              dir_q;    // DIR_LM / DIR_SM

  logic [NREG-1:0]   mask_d;
  logic [DATA_W-1:0] addr_d;
  logic [REG_AW-1:0] idx;
  logic              has_reg;
  logic              xfer_active;

`ifdef LMSM_BASE_WB_EN
  logic [REG_AW-1:0] base_reg_q;
`else
  // base_reg has no function without the writeback state.
  logic unused_base_reg;
  assign unused_base_reg = ^base_reg;
`endif

  lsb_prio_enc #(
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_enc (
    .mask_i  (mask_q),
    .idx_o   (idx),
    .valid_o (has_reg)
  );

  // A request is outstanding whenever XFER still has registers left.
  assign xfer_active = (state_q == ST_XFER) && has_reg;
  assign mask_d      = mask_q & ~(NREG'(1) << idx);
  assign addr_d      = addr_q + DATA_W'(1);  // wraps modulo 2^DATA_W

  // Controller FSM plus the latched transfer context.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      addr_q     <= '0;
      dir_q      <= DIR_LM;
`ifdef LMSM_BASE_WB_EN
      base_reg_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_q     <= reg_list;
            addr_q     <= base_addr;
            dir_q      <= is_store;
`ifdef LMSM_BASE_WB_EN
            base_reg_q <= base_reg;
`endif
            state_q    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!has_reg) begin
`ifdef LMSM_BASE_WB_EN
            state_q <= ST_WB;
`else
            state_q <= ST_DONE;
`endif
          end else if (mem_ack) begin
            mask_q <= mask_d;
            addr_q <= addr_d;
          end
        end
        ST_WB:   state_q <= ST_DONE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory and register-file ports; everything is zero outside active cycles.
  always_comb begin
    rf_raddr  = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (xfer_active) begin
      mem_req   = 1'b1;
      mem_we    = dir_q;
      mem_addr  = addr_q;
      mem_wdata = rf_rdata;
      rf_raddr  = idx;
      rf_waddr  = idx;
      if (mem_ack && (dir_q == DIR_LM)) begin
        rf_we    = 1'b1;
        rf_wdata = mem_rdata;
      end
    end
`ifdef LMSM_BASE_WB_EN
    if (state_q == ST_WB) begin
      rf_we    = 1'b1;
      rf_waddr = base_reg_q;
      rf_wdata = addr_q;
    end
`endif
  end

  assign busy = (state_q == ST_XFER) || (state_q == ST_WB);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: a list-level reference model pushes
// expected transfer/writeback/done records; a negedge monitor pops them.
module tb_lmsm_sequencer;

`ifdef LMSM_BASE_WB_EN
  localparam int FEAT = 1;
`else
  localparam int FEAT = 0;
`endif
  // record: {kind[1:0], mem_we, rf_we, rf_raddr[2:0], rf_waddr[2:0], addr[15:0], data[15:0]}
  localparam int EW = 42;

  // clock/reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
  logic [7:0]  reg_list = '0;
  logic [15:0] base_addr = '0;
  logic [2:0]  base_reg = '0;
  logic [15:0] rf_rdata, mem_rdata;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [15:0] rf_wdata, mem_addr, mem_wdata;
  logic        rf_we, mem_req, mem_we, busy, done;

  lmsm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .reg_list(reg_list), .base_addr(base_addr), .base_reg(base_reg),
    .rf_rdata(rf_rdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  // environment: memory is a fixed address hash, register file is an array
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  logic [15:0] rf_mem [8];
  logic [15:0] ref_regs [8];
  assign rf_rdata  = rf_mem[rf_raddr];
  assign mem_rdata = mem_fn(mem_addr);
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  // ack driver: 0 = every cycle, 1 = random, 2 = after 3 wait cycles
  int   ack_mode = 0;
  int   age = 0;
  logic last_ack = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      mem_ack = 1'b0;
      age = 0;
    end else begin
      if (mem_req) age = last_ack ? 1 : age + 1;
      else age = 0;
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = 1'($urandom_range(0, 1));
        default: mem_ack = (age >= 4);
      endcase
    end
  end
  always @(negedge clk) last_ack = mem_ack && mem_req;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic sb_pop(input logic [EW-1:0] o, input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL %s: got unexpected event %h expected no event (t=%0t)", name, o, $time);
    end else begin
      e = exp_q.pop_front();
      chk(name, 64'(o), 64'(e));
    end
  endtask

  // monitor
  logic        prev_pending = 1'b0;
  logic [20:0] prev_snap = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (done)
        sb_pop({2'd2, mem_we, rf_we, rf_raddr, rf_waddr, mem_addr, 14'd0, mem_req, busy}, "done_evt");
      else if (mem_req && mem_ack)
        sb_pop({2'd0, mem_we, rf_we, rf_raddr, rf_waddr, mem_addr, mem_we ? mem_wdata : rf_wdata}, "xfer_evt");
      else if (rf_we)
        sb_pop({2'd1, mem_we, rf_we, rf_raddr, rf_waddr, mem_addr, rf_wdata}, "wb_evt");
      if (mem_req && !mem_ack) chk("no_rf_we_while_waiting", 64'(rf_we), 64'd0);
      if (prev_pending) chk("req_held_until_ack", 64'({mem_req, mem_we, mem_addr, rf_raddr}), 64'(prev_snap));
      prev_pending = mem_req && !mem_ack;
      prev_snap = {1'b1, mem_we, mem_addr, rf_raddr};
    end else begin
      prev_pending = 1'b0;
    end
  end

  // driver: one complete LM/SM with the reference model's expectations
  task automatic run_xfer(input logic dir, input logic [7:0] list, input logic [15:0] base,
                          input logic [2:0] breg, input int mode, input bit noise);
    logic [15:0] a;
    int start_cyc;
    bit seen;
    @(posedge clk); #1;
    ack_mode = mode;
    start = 1'b1; is_store = dir; reg_list = list; base_addr = base; base_reg = breg;
    a = base;
    for (int i = 0; i < 8; i++) begin
      if (list[i]) begin
        if (dir) exp_q.push_back({2'd0, 1'b1, 1'b0, 3'(i), 3'(i), a, ref_regs[i]});
        else begin
          exp_q.push_back({2'd0, 1'b0, 1'b1, 3'(i), 3'(i), a, mem_fn(a)});
          ref_regs[i] = mem_fn(a);
        end
        a = a + 16'd1;
      end
    end
    if (FEAT == 1) begin
      exp_q.push_back({2'd1, 1'b0, 1'b1, 3'd0, breg, 16'd0, a});
      ref_regs[breg] = a;
    end
    exp_q.push_back({2'd2, 40'd0});
    start_cyc = cyc;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk); #1;
      if (noise) begin
        start = 1'($urandom_range(0, 1)); is_store = ~dir; reg_list = ~list;
        base_addr = 16'($urandom); base_reg = ~breg;
      end else start = 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      chk_cnt++;
      $display("FAIL done_timeout: got no done in 400 cycles expected done");
      exp_q.delete();
    end else if (mode == 0) begin
      chk("done_latency", 64'(cyc - start_cyc), 64'($countones(list) + 2 + FEAT));
    end
    @(posedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // reset asserted during the second transfer of an 8-register LM
  task automatic run_reset_mid();
    @(posedge clk); #1;
    ack_mode = 0;
    start = 1'b1; is_store = 1'b0; reg_list = 8'hFF; base_addr = 16'h0200;
    exp_q.push_back({2'd0, 1'b0, 1'b1, 3'd0, 3'd0, 16'h0200, mem_fn(16'h0200)});
    ref_regs[0] = mem_fn(16'h0200);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_outputs", 64'({mem_req, rf_we, done, busy, mem_we, mem_addr, rf_waddr, rf_wdata}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("reset_idle_busy", 64'(busy), 64'd0);
    chk("reset_r0_written", 64'(rf_mem[0]), 64'(ref_regs[0]));
    chk("reset_r1_untouched", 64'(rf_mem[1]), 64'(ref_regs[1]));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 16'($urandom);
      ref_regs[i] = rf_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({mem_req, mem_we, rf_we, busy, done, mem_addr, rf_raddr, rf_waddr, rf_wdata}), 64'd0);
    chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk) reset = 1'b1;

    run_xfer(1'b0, 8'b1000_0101, 16'h0010, 3'd3, 0, 1'b0);  // LM, ack every cycle
    run_xfer(1'b1, 8'b0000_0110, 16'h0100, 3'd4, 2, 1'b0);  // SM, delayed acks
    run_xfer(1'b0, 8'h00,        16'h1234, 3'd5, 0, 1'b0);  // empty list
    run_xfer(1'b0, 8'h03,        16'hFFFF, 3'd1, 0, 1'b0);  // address wrap
    run_xfer(1'b1, 8'h3C,        16'h0400, 3'd6, 0, 1'b1);  // start pulsed while busy
    run_xfer(1'b0, 8'h5A,        16'h0800, 3'd2, 1, 1'b1);
    run_reset_mid();
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  l;
      logic [15:0] b;
      l = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      run_xfer(1'($urandom_range(0, 1)), l, b, 3'($urandom_range(0, 7)),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    run_xfer(1'b1, 8'hFF, 16'hC000, 3'd0, 1, 1'b0);          // read back every register

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
